// File: rtl/btb_counter_predictor.sv
// Direct-mapped tagged BTB with saturating direction counters, a static BTFN fallback on a miss, and a saturating mispredict counter.
// Define BTB_GSHARE_EN to index the direction counters with the PC index XOR a global history register.
module btb_counter_predictor #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic               frontend_stall,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               overwrite_pc,
  output logic               pred_hit,
  input  logic               flush,
  input  logic               update_valid,
  input  logic [ADDR_W-1:0]  update_pc,
  input  logic [ADDR_W-1:0]  update_target,
  input  logic               update_taken,
  input  logic               update_mispredict,
  output logic [STAT_W-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_MAX >> 1;
  localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(1) << (CTR_W - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [STAT_W-1:0] mispredCount_q, mispredCount_d;

  logic [IDX_W-1:0]  lkIdx, lkDirIdx, upIdx, upDirIdx;
  logic [TAG_W-1:0]  lkTag, upTag;
  logic              lkHit, upHit;
  logic [CTR_W-1:0]  lkCtr, upCtr;
  logic [CTR_W-1:0]  ctrNext_d;
  logic [ADDR_W-1:0] targetNext_d;
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] pcPlus4, brImm, jalImm;

  assign lkIdx = pc[IDX_W+1:2];
  assign lkTag = pc[ADDR_W-1:IDX_W+2];
  assign upIdx = update_pc[IDX_W+1:2];
  assign upTag = update_pc[ADDR_W-1:IDX_W+2];

`ifdef BTB_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [IDX_W:0]   ghrShift;

  assign ghrShift = {ghr_q, update_taken};
  assign ghr_d    = (update_valid && !frontend_stall) ? ghrShift[IDX_W-1:0] : ghr_q;
  assign lkDirIdx = lkIdx ^ ghr_q;
  assign upDirIdx = upIdx ^ ghr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^update_pc[1:0];
`else
  assign lkDirIdx = lkIdx;
  assign upDirIdx = upIdx;

  logic unused_bits;
  assign unused_bits = ^{update_pc[1:0], frontend_stall};
`endif

  assign lkHit = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
  assign lkCtr = ctr_q[lkDirIdx];
  assign upHit = valid_q[upIdx] && (tag_q[upIdx] == upTag);
  assign upCtr = ctr_q[upDirIdx];

  assign opcode  = instruction[6:0];
  assign pcPlus4 = pc + ADDR_W'(4);
  assign brImm   = {{(ADDR_W-12){instruction[31]}}, instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
  assign jalImm  = {{(ADDR_W-20){instruction[31]}}, instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};

  // Lookup sees only registered table state; a same-cycle update is not bypassed.
  always_comb begin
    next_pc      = pcPlus4;
    overwrite_pc = 1'b0;
    pred_hit     = 1'b0;
    if (fetch_valid && !flush) begin
      case (opcode)
        OPC_BRANCH: begin
          pred_hit = lkHit;
          if (lkHit) begin
            if (lkCtr[CTR_W-1]) begin
              next_pc      = target_q[lkIdx];
              overwrite_pc = 1'b1;
            end
          end else if (brImm[ADDR_W-1]) begin
            next_pc      = pc + brImm;
            overwrite_pc = 1'b1;
          end
        end
        OPC_JAL: begin
          next_pc      = pc + jalImm;
          overwrite_pc = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    ctrNext_d    = update_taken ? WEAK_T : WEAK_NT;
    targetNext_d = update_target;
    if (upHit) begin
      if (update_taken) begin
        ctrNext_d = (upCtr == CTR_MAX) ? upCtr : upCtr + CTR_W'(1);
      end else begin
        ctrNext_d    = (upCtr == '0) ? upCtr : upCtr - CTR_W'(1);
        targetNext_d = target_q[upIdx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WEAK_NT;
      end
    end else if (update_valid) begin
      valid_q[upIdx]    <= 1'b1;
      tag_q[upIdx]      <= upTag;
      target_q[upIdx]   <= targetNext_d;
      ctr_q[upDirIdx]   <= ctrNext_d;
    end
  end

  always_comb begin
    mispredCount_d = mispredCount_q;
    if (update_valid && update_mispredict && (mispredCount_q != '1)) begin
      mispredCount_d = mispredCount_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredCount_q <= '0;
    end else begin
      mispredCount_q <= mispredCount_d;
    end
  end

  assign mispredict_count = mispredCount_q;

endmodule

// File: tb/tb_btb_counter_predictor.sv
// Scoreboard bench for btb_counter_predictor (default build, ENTRIES=64); a second instance with STAT_W=2 covers counter saturation.
module tb_btb_counter_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        frontend_stall = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] instruction = '0;
  logic        flush = 1'b0;
  logic        update_valid = 1'b0;
  logic [63:0] update_pc = '0;
  logic [63:0] update_target = '0;
  logic        update_taken = 1'b0;
  logic        update_mispredict = 1'b0;

  logic [63:0] next_pc;
  logic        overwrite_pc;
  logic        pred_hit;
  logic [31:0] mispredict_count;

  logic [63:0] unused_nextPc2;
  logic        unused_overwrite2;
  logic        unused_hit2;
  logic [1:0]  mispredictCount2;

  localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
  localparam logic [31:0] BEQ_P16 = 32'h00000863;
  localparam logic [31:0] JAL_P16 = 32'h0100006F;
  localparam logic [31:0] ADDI    = 32'h00000013;

  typedef struct {
    string       name;
    logic [63:0] nextPc;
    logic        overwrite;
    logic        hit;
  } lookupExp_t;

  lookupExp_t expQ[$];
  int checks = 0;
  int failures = 0;
  int modelCount = 0;
  int modelCount2 = 0;

  btb_counter_predictor dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .frontend_stall(frontend_stall),
    .pc(pc), .instruction(instruction), .next_pc(next_pc), .overwrite_pc(overwrite_pc),
    .pred_hit(pred_hit), .flush(flush), .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .update_mispredict(update_mispredict), .mispredict_count(mispredict_count)
  );

  btb_counter_predictor #(.STAT_W(2)) dutSat (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .frontend_stall(frontend_stall),
    .pc(pc), .instruction(instruction), .next_pc(unused_nextPc2), .overwrite_pc(unused_overwrite2),
    .pred_hit(unused_hit2), .flush(flush), .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .update_mispredict(update_mispredict), .mispredict_count(mispredictCount2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic compareLookup();
    lookupExp_t e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({e.name, "_next_pc"}, next_pc, e.nextPc);
      checkOutput({e.name, "_overwrite"}, {63'd0, overwrite_pc}, {63'd0, e.overwrite});
      checkOutput({e.name, "_hit"}, {63'd0, pred_hit}, {63'd0, e.hit});
    end
  endtask

  // Called just after a falling edge; outputs are compared 1ns later, well before the next rising edge.
  task automatic applyStimulus(input string name, input logic [63:0] pcIn, input logic [31:0] instr,
                               input logic fv, input logic fl, input logic [63:0] expNext,
                               input logic expOv, input logic expHit);
    lookupExp_t e;
    pc = pcIn;
    instruction = instr;
    fetch_valid = fv;
    flush = fl;
    e.name = name;
    e.nextPc = expNext;
    e.overwrite = expOv;
    e.hit = expHit;
    expQ.push_back(e);
    #1;
    compareLookup();
  endtask

  task automatic driveUpdate(input logic [63:0] upPc, input logic [63:0] target, input logic taken,
                             input logic mis, input logic valid);
    update_valid = valid;
    update_pc = upPc;
    update_target = target;
    update_taken = taken;
    update_mispredict = mis;
    @(posedge clk);
    if (valid && mis) begin
      if (modelCount != 32'hFFFF_FFFF) modelCount++;
      if (modelCount2 != 3) modelCount2++;
    end
    @(negedge clk);
    update_valid = 1'b0;
    update_mispredict = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_count", {32'd0, mispredict_count}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus("t1_beq_back", 64'h100, BEQ_M8, 1'b1, 1'b0, 64'hF8, 1'b1, 1'b0);

    applyStimulus("t2_miss_fwd", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h204, 1'b0, 1'b0);
    driveUpdate(64'h200, 64'h210, 1'b1, 1'b0, 1'b1);
    applyStimulus("t2_hit_taken", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h210, 1'b1, 1'b1);
    driveUpdate(64'h200, 64'h210, 1'b0, 1'b0, 1'b1);
    driveUpdate(64'h200, 64'h210, 1'b0, 1'b0, 1'b1);
    applyStimulus("t2_hit_nt", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h204, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) driveUpdate(64'h200, 64'h210, 1'b1, 1'b0, 1'b1);
    applyStimulus("t3_strong_t", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h210, 1'b1, 1'b1);
    driveUpdate(64'h200, 64'h210, 1'b0, 1'b0, 1'b1);
    applyStimulus("t3_weak_t", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h210, 1'b1, 1'b1);

    driveUpdate(64'h200, 64'h210, 1'b1, 1'b0, 1'b1);
    applyStimulus("t4_alias_fwd", 64'h300, BEQ_P16, 1'b1, 1'b0, 64'h304, 1'b0, 1'b0);
    applyStimulus("t4_alias_back", 64'h300, BEQ_M8, 1'b1, 1'b0, 64'h2F8, 1'b1, 1'b0);
    driveUpdate(64'h300, 64'h400, 1'b1, 1'b0, 1'b1);
    applyStimulus("t4_evicted", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h204, 1'b0, 1'b0);
    applyStimulus("t4_new_owner", 64'h300, BEQ_P16, 1'b1, 1'b0, 64'h400, 1'b1, 1'b1);

    update_valid = 1'b1;
    update_pc = 64'h200;
    update_target = 64'h250;
    update_taken = 1'b1;
    applyStimulus("t5_same_cycle", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h204, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    update_valid = 1'b0;
    applyStimulus("t5_after", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h250, 1'b1, 1'b1);
    applyStimulus("t5_jal", 64'h500, JAL_P16, 1'b1, 1'b0, 64'h510, 1'b1, 1'b0);
    applyStimulus("t5_jal_flush", 64'h500, JAL_P16, 1'b1, 1'b1, 64'h504, 1'b0, 1'b0);
    applyStimulus("t5_flush_hit", 64'h200, BEQ_P16, 1'b1, 1'b1, 64'h204, 1'b0, 1'b0);
    applyStimulus("t5_no_valid", 64'h500, JAL_P16, 1'b0, 1'b0, 64'h504, 1'b0, 1'b0);
    applyStimulus("t5_other_op", 64'h600, ADDI, 1'b1, 1'b0, 64'h604, 1'b0, 1'b0);
    applyStimulus("t5_wrap", 64'hFFFF_FFFF_FFFF_FFFC, ADDI, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus("t5_flush_kept", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h250, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) driveUpdate(64'h104, 64'h900, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("t6_count", {32'd0, mispredict_count}, 64'(modelCount));
    checkOutput("t6_count_sat", {62'd0, mispredictCount2}, 64'(modelCount2));
    @(negedge clk);
    driveUpdate(64'h104, 64'h900, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("t6_count_gated", {32'd0, mispredict_count}, 64'(modelCount));

    @(posedge clk);
    #2;
    reset = 1'b0;
    modelCount = 0;
    modelCount2 = 0;
    #1;
    checkOutput("t6_reset_count", {32'd0, mispredict_count}, 64'(modelCount));
    checkOutput("t6_reset_count_sat", {62'd0, mispredictCount2}, 64'(modelCount2));
    applyStimulus("t6_reset_miss", 64'h200, BEQ_P16, 1'b1, 1'b0, 64'h204, 1'b0, 1'b0);
    applyStimulus("t6_reset_miss2", 64'h104, BEQ_M8, 1'b1, 1'b0, 64'hFC, 1'b1, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    if (expQ.size() != 0) checkOutput("scoreboard_leftover", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
